// File: rtl/game_pkg.sv
// Shared types for the adventure-game input scheduler.
//   dir_t         : 2-bit move direction code (N=0, E=1, S=2, W=3)
//   sched_state_t : move scheduler FSM states
//   DIR_FIFO_DEPTH: depth of the accepted-press queue
package game_pkg;
  localparam int DIR_FIFO_DEPTH = 4;
  localparam int NUM_DIRS       = 4;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    OVER  = 2'd3
  } sched_state_t;

  // Fixed priority: the lowest code (N) wins.
  function automatic dir_t arb_pick(input logic [NUM_DIRS-1:0] ev);
    arb_pick = DIR_W;
    for (int i = NUM_DIRS - 1; i >= 0; i--)
      if (ev[i]) arb_pick = dir_t'(i);
  endfunction

  function automatic logic [NUM_DIRS-1:0] dir_onehot(input dir_t d);
    dir_onehot    = '0;
    dir_onehot[d] = 1'b1;
  endfunction
endpackage

// File: rtl/move_scheduler_if.sv
// Board-side bundle of the move scheduler.
//   master: drives buttons and die/win, observes moves/status (board / bench)
//   slave : the scheduler itself
interface move_scheduler_if #(parameter int MOVE_W = 8);
  logic              btn_n, btn_s, btn_e, btn_w;
  logic              die, win;
  logic              n, s, e, w;
  logic              busy, over, drop;
  logic [MOVE_W-1:0] moves;

  modport master (
    output btn_n, btn_s, btn_e, btn_w, die, win,
    input  n, s, e, w, busy, over, drop, moves
  );
  modport slave (
    input  btn_n, btn_s, btn_e, btn_w, die, win,
    output n, s, e, w, busy, over, drop, moves
  );
endinterface

// File: rtl/btn_filter.sv
// Per-button press filter.
//   clk, reset : clock, synchronous active-high reset
//   btn        : raw level, already synchronous to clk
//   evt        : registered one-cycle press event
// An event fires on the edge where the HOLD_CYCLES-th consecutive high
// sample is taken. The filter then disarms until a low sample is seen;
// it also starts disarmed so a button held through reset stays silent.
module btn_filter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;
  logic          evt_q, evt_d;

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    evt_d   = 1'b0;
    if (!btn) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
        evt_d   = 1'b1;
        armed_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      evt_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      evt_q   <= evt_d;
    end
  end

  assign evt = evt_q;
endmodule

// File: rtl/move_scheduler.sv
// Input-side controller for the room FSM.
//   clk, reset : clock, synchronous active-high reset
//   bus.slave  : btn_n/s/e/w raw buttons, die/win status in;
//                n/s/e/w move pulses, busy, over, drop, moves out
// Filtered presses are arbitrated (N > E > S > W), queued in a small FIFO
// and issued as one-cycle pulses followed by GAP_CYCLES idle cycles.
// die/win freezes everything in OVER until reset.
module move_scheduler
  import game_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int MOVE_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  move_scheduler_if.slave  bus
);
  localparam int PW = $clog2(DIR_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [NUM_DIRS-1:0] btn_vec, evt;

  // Indexed by direction code.
  assign btn_vec = {bus.btn_w, bus.btn_s, bus.btn_e, bus.btn_n};

  btn_filter #(.HOLD_CYCLES(HOLD_CYCLES)) u_flt [NUM_DIRS-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (btn_vec),
    .evt   (evt)
  );

  sched_state_t                        state_q, state_d;
  dir_t                                issue_q, issue_d;
  logic [GW-1:0]                       gap_q, gap_d;
  logic [DIR_FIFO_DEPTH-1:0][1:0]      fifo_q, fifo_d;
  logic [PW-1:0]                       wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [MOVE_W-1:0]                   moves_q, moves_d;
  logic [NUM_DIRS-1:0]                 mv_q, mv_d;
  logic                                drop_q, drop_d;

  logic pop, push, empty, full, multi, gap_last, end_game;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DIR_FIFO_DEPTH));
  assign multi    = |(evt & (evt - 1'b1));
  assign gap_last = (gap_q == GW'(GAP_CYCLES - 1));
  assign end_game = bus.die | bus.win;

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    gap_d   = gap_q;
    fifo_d  = fifo_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    moves_d = moves_q;
    mv_d    = '0;
    drop_d  = 1'b0;
    pop     = 1'b0;
    push    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = '0;
        state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_last) begin
          if (!empty) begin
            pop     = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: ;
    endcase

    if (pop) begin
      issue_d = dir_t'(fifo_q[rd_q]);
      rd_d    = rd_q + 1'b1;
    end

    // A push into a full queue still fits if the head leaves on this edge.
    if (state_q != OVER && evt != '0) begin
      if (full && !pop) drop_d = 1'b1;
      else              push   = 1'b1;
      if (multi)        drop_d = 1'b1;
    end

    if (push) begin
      fifo_d[wr_q] = arb_pick(evt);
      wr_d         = wr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase

    // Game end wins over any pop/issue and flushes the queue.
    if (end_game) begin
      state_d = OVER;
      issue_d = issue_q;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      drop_d  = 1'b0;
    end

    // Pulse and count are decoded from the next state so the pulse is
    // high in the cycle right after ISSUE is entered.
    if (state_d == ISSUE) begin
      mv_d = dir_onehot(issue_d);
      if (moves_q != '1) moves_d = moves_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      issue_q <= DIR_N;
      gap_q   <= '0;
      fifo_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      moves_q <= '0;
      mv_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      gap_q   <= gap_d;
      fifo_q  <= fifo_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      moves_q <= moves_d;
      mv_q    <= mv_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.n     = mv_q[DIR_N];
  assign bus.e     = mv_q[DIR_E];
  assign bus.s     = mv_q[DIR_S];
  assign bus.w     = mv_q[DIR_W];
  assign bus.busy  = !empty || (state_q != IDLE);
  assign bus.over  = (state_q == OVER);
  assign bus.drop  = drop_q;
  assign bus.moves = moves_q;
endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a pulse scoreboard.
// Expected pulses (direction + cycle) are queued as stimulus is applied;
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_move_scheduler;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       reset, rst_sat;
  logic [3:0] btn;
  logic       die;
  int         cyc = 0, tests = 0, fails = 0, drop_cnt = 0;

  typedef struct { int dir; int cyc; } exp_t;
  exp_t expq[$];

  // Overflow scenario: {cycle offset, button code, level}
  int ovf_tbl [14][3] = '{
    '{0,0,1}, '{1,1,1}, '{2,2,1}, '{3,3,1}, '{5,0,0}, '{6,0,1}, '{6,1,0},
    '{7,1,1}, '{7,2,0}, '{8,2,1}, '{8,3,0}, '{10,3,1}, '{11,0,0}, '{12,0,1}
  };

  move_scheduler_if #(.MOVE_W(8)) bus_m();
  move_scheduler_if #(.MOVE_W(2)) bus_s();

  assign bus_m.btn_n = btn[0];
  assign bus_m.btn_e = btn[1];
  assign bus_m.btn_s = btn[2];
  assign bus_m.btn_w = btn[3];
  assign bus_m.die   = die;
  assign bus_m.win   = 1'b0;
  assign bus_s.btn_n = btn[0];
  assign bus_s.btn_e = btn[1];
  assign bus_s.btn_s = btn[2];
  assign bus_s.btn_w = btn[3];
  assign bus_s.die   = 1'b0;
  assign bus_s.win   = 1'b0;

  move_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .MOVE_W(8)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_m.slave));
  move_scheduler #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .MOVE_W(2)) u_sat (
    .clk(clk), .reset(rst_sat), .bus(bus_s.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: cycle %0d reached time limit", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic go(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] pv;
    exp_t       ex;
    int         d;
    pv = {bus_m.w, bus_m.s, bus_m.e, bus_m.n};
    if (bus_m.drop === 1'b1) drop_cnt++;
    if (pv !== 4'b0) begin
      tests++;
      d = 0;
      for (int i = 0; i < 4; i++) if (pv[i]) d = i;
      if ($countones(pv) != 1) begin
        fails++;
        $display("FAIL pulse_onehot: got %b expected one-hot (cycle %0d)", pv, cyc);
      end else if (expq.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got dir %0d at cycle %0d expected none", d, cyc);
      end else begin
        ex = expq.pop_front();
        if (ex.dir != d || ex.cyc != cyc) begin
          fails++;
          $display("FAIL pulse: got dir %0d at cycle %0d expected dir %0d at cycle %0d",
                   d, cyc, ex.dir, ex.cyc);
        end
      end
    end
  end

  initial begin
    int c, d0;
    reset = 1'b1; rst_sat = 1'b1; btn = '0; die = 1'b0;
    go(3);
    chk("reset_pulses", {bus_m.w, bus_m.s, bus_m.e, bus_m.n}, 0);
    chk("reset_busy",   bus_m.busy, 0);
    chk("reset_over",   bus_m.over, 0);
    chk("reset_drop",   bus_m.drop, 0);
    chk("reset_moves",  bus_m.moves, 0);
    chk("reset_moves_sat", bus_s.moves, 0);
    reset = 1'b0; rst_sat = 1'b0;
    go(6);

    // Single press, held 10 cycles: one pulse, no repeat.
    c = cyc;
    btn[1] = 1'b1;
    expq.push_back('{1, c + 6});
    go(c + 10);
    btn[1] = 1'b0;
    chk("single_moves", bus_m.moves, 1);
    chk("single_busy",  bus_m.busy, 0);
    chk("single_sat",   bus_s.moves, 1);
    go(c + 13);

    // Burst N, S, W on consecutive edges: spacing 3.
    c = cyc;
    btn[0] = 1'b1;
    expq.push_back('{0, c + 6});
    expq.push_back('{2, c + 9});
    expq.push_back('{3, c + 12});
    go(c + 1); btn[2] = 1'b1;
    go(c + 2); btn[3] = 1'b1;
    go(c + 8); btn = '0;
    go(c + 14); chk("burst_busy_gap", bus_m.busy, 1);
    go(c + 15); chk("burst_busy_idle", bus_m.busy, 0);
    chk("burst_moves", bus_m.moves, 4);
    go(c + 17);

    // N and W together: N wins, one drop.
    c = cyc; d0 = drop_cnt;
    btn[0] = 1'b1; btn[3] = 1'b1;
    expq.push_back('{0, c + 6});
    go(c + 8); btn = '0;
    go(c + 12);
    chk("simul_drop",  drop_cnt - d0, 1);
    chk("simul_moves", bus_m.moves, 5);
    chk("sat_moves_5", bus_s.moves, 3);

    // Overflow: one push meets a full queue with a pop (kept), one without (dropped).
    c = cyc; d0 = drop_cnt;
    for (int i = 0; i < 8; i++) expq.push_back('{i % 4, c + 6 + 3 * i});
    for (int k = 0; k <= 12; k++) begin
      go(c + k);
      for (int j = 0; j < 14; j++)
        if (ovf_tbl[j][0] == k) btn[ovf_tbl[j][1]] = (ovf_tbl[j][2] != 0);
    end
    go(c + 16); chk("ovf_busy", bus_m.busy, 1);
    go(c + 20); btn = '0;
    go(c + 31);
    chk("ovf_drop",  drop_cnt - d0, 1);
    chk("ovf_moves", bus_m.moves, 13);
    chk("ovf_idle",  bus_m.busy, 0);

    // die during GAP with two entries queued.
    c = cyc; d0 = drop_cnt;
    btn[0] = 1'b1;
    expq.push_back('{0, c + 6});
    go(c + 1); btn[1] = 1'b1;
    go(c + 2); btn[2] = 1'b1;
    go(c + 7);
    chk("over_before", bus_m.over, 0);
    die = 1'b1;
    go(c + 8);
    chk("over_rise", bus_m.over, 1);
    chk("over_busy", bus_m.busy, 1);
    go(c + 9);  btn = '0;
    go(c + 10); btn[0] = 1'b1; btn[3] = 1'b1;
    go(c + 16); btn = '0; die = 1'b0;
    go(c + 20);
    chk("over_hold",  bus_m.over, 1);
    chk("over_drop",  drop_cnt - d0, 0);
    chk("over_moves", bus_m.moves, 14);
    reset = 1'b1;
    go(c + 21); reset = 1'b0;
    go(c + 22);
    chk("over_exit",  bus_m.over, 0);
    chk("over_clear", bus_m.moves, 0);

    // Reset during ISSUE with S held; S must be re-pressed.
    c = cyc;
    btn[2] = 1'b1;
    expq.push_back('{2, c + 6});
    go(c + 6); reset = 1'b1;
    go(c + 7);
    chk("rst_pulses", {bus_m.w, bus_m.s, bus_m.e, bus_m.n}, 0);
    chk("rst_busy",   bus_m.busy, 0);
    chk("rst_moves",  bus_m.moves, 0);
    chk("rst_drop",   bus_m.drop, 0);
    go(c + 8);  reset = 1'b0;
    go(c + 20); btn[2] = 1'b0;
    go(c + 22); btn[2] = 1'b1;
    expq.push_back('{2, c + 28});
    go(c + 30); btn = '0;
    go(c + 34);
    chk("rst_repress_moves", bus_m.moves, 1);
    chk("rst_repress_busy",  bus_m.busy, 0);

    go(cyc + 5);
    chk("pending_pulses", expq.size(), 0);
    chk("sat_final", bus_s.moves, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/move_scheduler.md
# move_scheduler

Input-side controller for the adventure-game room FSM. Filters four raw direction buttons, queues accepted presses in a 4-entry FIFO and issues them as one-cycle `n`/`s`/`e`/`w` move pulses with a minimum spacing. Freezes all play once the room FSM reports `die` or `win`. Sits between the board buttons and the `n`/`s`/`e`/`w` inputs of the game top level. `die`/`win` are fed back from that top level.

## Interface
- `HOLD_CYCLES`, 4: consecutive high samples before a press is accepted (≥1).
- `GAP_CYCLES`, 2: idle cycles forced after each issued move (≥0).
- `MOVE_W`, 8: width of the move counter.
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears every register.
- `btn_n`, `btn_s`, `btn_e`, `btn_w`  in  1 each  raw button levels, already synchronous to `clk`.
- `die`, `win`  in  1 each  status levels from the room FSM.
- `n`, `s`, `e`, `w`  out  1 each  registered one-cycle move pulses to the room FSM.
- `busy`  out  1  high while FIFO is non-empty or state ≠ IDLE.
- `over`  out  1  high in OVER state.
- `drop`  out  1  one-cycle pulse when an accepted press is discarded.
- `moves`  out  MOVE_W  count of issued moves; saturates at all-ones.

## Operation
- **Filter (per button):**
  - Counter of consecutive high samples.
  - A press event fires once, registered, on the edge where the count reaches `HOLD_CYCLES`.
  - No further event until the button has been sampled low.
  - After reset each filter is disarmed until it sees one low sample, so a button held through reset never generates a move.
- **Event arbitration:**
  - Same-edge events resolve by fixed priority N > E > S > W.
  - The winner is pushed. Losers are discarded and pulse `drop`.
- **FIFO:**
  - 4 entries of 2-bit direction codes: N=0, E=1, S=2, W=3.
  - Push to a full FIFO is discarded and pulses `drop`, unless a pop occurs on the same edge. In that case the push is accepted.
- **States:**
  - IDLE: FIFO non-empty → pop head into issue register, go to ISSUE.
  - ISSUE (1 cycle): output matching pulse, increment `moves` (saturating). Then go to GAP, or to IDLE if `GAP_CYCLES`=0.
  - GAP: count `GAP_CYCLES` cycles. On the last one, FIFO non-empty → pop and go to ISSUE directly; empty → IDLE.
  - OVER: all move outputs 0, FIFO held empty, filter events ignored (no `drop`), `moves` frozen. Exit only by `reset`.
- **Game end:**
  - `die|win` sampled high on any edge in any non-OVER state → next state OVER.
  - Overrides any pop or issue on that edge.
  - FIFO flushed on the same edge.

## Timing
- Reset values: `n`, `s`, `e`, `w`, `busy`, `over`, `drop` = 0; `moves` = 0; FIFO empty; state IDLE; filters disarmed.
- Idle latency, with the button first sampled high at edge 0:
  - event at edge `HOLD_CYCLES`-1
  - push at edge `HOLD_CYCLES`
  - ISSUE entered at edge `HOLD_CYCLES`+1
  - pulse high for the cycle after that edge.
- Back-to-back issued pulses are spaced exactly `GAP_CYCLES`+1 cycles, rising edge to rising edge.
- Outputs `n`/`s`/`e`/`w`:
  - decoded from state == ISSUE plus the issue register, registered
  - never more than one high at a time
  - never high for more than 1 cycle.
- `drop` is registered, high for 1 cycle per discarded event; two losers on one edge give a single pulse.
- `over` rises 1 cycle after `die`/`win` is sampled.

## Structure
- Package `game_pkg`:
  - `dir_t` (2-bit codes above)
  - `sched_state_t` (IDLE, ISSUE, GAP, OVER)
  - FIFO depth constant `DIR_FIFO_DEPTH` = 4.
- Sub-module `btn_filter` (counter + armed flag + event register), instantiated four times.
- FIFO and FSM inline in `move_scheduler`.

## Test plan
- **Single press, defaults:** `btn_e` high from edge 0 for 10 cycles → `e` high for exactly the cycle after edge 5; `moves`=1; no repeat while held.
- **Burst queueing:** presses N, S, W accepted on consecutive edges → pulses `n`, `s`, `w` spaced 3 cycles; `busy` low after the last GAP.
- **Simultaneous and overflow:**
  - `btn_n` and `btn_w` rise together → only `n` issued, one `drop` pulse.
  - 6 accepted presses with no pop (FIFO filled while ISSUE/GAP runs) → extra pushes dropped, FIFO never exceeds 4.
- **Game end:** `die` asserted during GAP with 2 entries queued → `over`=1 next cycle, no further pulses, new presses give no `drop`, `moves` frozen until `reset`.
- **Reset mid-operation:**
  - `reset` during ISSUE with `btn_s` held → all outputs 0 next cycle.
  - No `s` pulse until `btn_s` is released and re-pressed for 4 cycles.
- **Saturation:** `MOVE_W`=2, 5 moves → `moves` stops at 3.
